// File: rtl/gate_preactivation_mac.sv
// Gate pre-activation multiply-accumulate.
// Computes sat(floor(sum(weight[i]*data[i]) / 2^QM) + bias) over VLEN
// streamed weight/data pairs. All operands are signed Q(QN).(QM) fixed
// point. The result feeds the sigmoid/tanh stage of a recurrent cell.
module gate_preactivation_mac #(
  parameter int QN   = 6,
  parameter int QM   = 11,
  parameter int VLEN = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [QN+QM:0]     bias,
  input  logic                      in_valid,
  input  logic signed [QN+QM:0]     weight,
  input  logic signed [QN+QM:0]     data,
  output logic                      in_ready,
  output logic                      busy,
  output logic signed [QN+QM:0]     result,
  output logic                      done
);

  localparam int BW   = QN + QM + 1;
  localparam int PW   = 2 * BW;
  localparam int ACCW = 2 * BW + 8;
  localparam int CW   = $clog2(VLEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(VLEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                   state;
  logic signed [ACCW-1:0]   acc;
  logic        [CW-1:0]     cnt;
  logic signed [BW-1:0]     bias_q;

  logic signed [PW-1:0]     prod;
  logic signed [ACCW-1:0]   prod_ext;
  logic signed [ACCW-1:0]   acc_shr;
  logic signed [ACCW-1:0]   bias_ext;
  logic signed [ACCW-1:0]   sum;
  logic                     sum_ovf;
  logic signed [BW-1:0]     sat_sum;

  // Full-precision product and its sign extension to accumulator width.
  assign prod     = weight * data;
  assign prod_ext = $signed({{(ACCW-PW){prod[PW-1]}}, prod});

  // Rescale and saturate the finished accumulator; all terms are kept
  // signed so the shift is arithmetic (floor toward minus infinity).
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_shr  = acc >>> QM;
    bias_ext = $signed({{(ACCW-BW){bias_q[BW-1]}}, bias_q});
    sum      = acc_shr + bias_ext;
    sum_ovf  = (sum[ACCW-1:BW-1] != {(ACCW-BW+1){sum[ACCW-1]}});
    sat_sum  = sum[BW-1:0];
    if (sum_ovf) begin
      sat_sum = sum[ACCW-1] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
    end
  end

  // Control FSM with datapath registers and registered status outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      bias_q   <= '0;
      result   <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            acc      <= '0;
            cnt      <= '0;
            bias_q   <= bias;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc <= acc + prod_ext;
            if (cnt == LAST_IDX) begin
              state    <= FINISH;
              in_ready <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FINISH: begin
          result <= sat_sum;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
